// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: sequential fetch, taken-branch redirect with a timed IF/ID squash,
// BL link-register write and a saturating taken-branch counter.
module fetch_pc_unit #(
    parameter int unsigned        ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int unsigned        FLUSH_CYCLES = 1,
    parameter int unsigned        CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              t_address,
    input  logic              bl_reg,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_valid,
    output logic              if_id_flush,
    output logic              lr_we,
    output logic [ADDR_W-1:0] lr_data,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    localparam logic [1:0]        CntInit = 2'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PcStep  = ADDR_W'(4);
    localparam state_e            RedirSt = (FLUSH_CYCLES > 1) ? StFlush : StRun;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   lr_data_q, lr_data_d;
    logic                flush_q, flush_d;
    logic                lr_we_q, lr_we_d;
    logic                valid_q;
    logic [CNT_W-1:0]    count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            pc_q      <= RESET_PC;
            lr_data_q <= '0;
            flush_q   <= 1'b0;
            lr_we_q   <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            lr_data_q <= lr_data_d;
            flush_q   <= flush_d;
            lr_we_q   <= lr_we_d;
            valid_q   <= 1'b1;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        lr_data_d = lr_data_q;
        flush_d   = flush_q;
        lr_we_d   = 1'b0;
        count_d   = count_q;
        // The first edge out of reset only raises fetch_valid; RESET_PC is fetched once.
        if (valid_q) begin
            case (state_q)
                StRun: begin
                    // A branch seen while a single-cycle squash is active is itself wrong-path.
                    if (t_address && !flush_q) begin
                        pc_d    = {branch_target[ADDR_W-1:2], 2'b00};
                        flush_d = 1'b1;
                        cnt_d   = CntInit;
                        state_d = RedirSt;
                        if (count_q != '1) count_d = count_q + CNT_W'(1);
                        if (bl_reg) begin
                            lr_we_d   = 1'b1;
                            lr_data_d = id_pc + PcStep;
                        end
                    end else begin
                        flush_d = 1'b0;
                        if (!stall) pc_d = pc_q + PcStep;
                    end
                end
                StFlush: begin
                    if (!stall) begin
                        pc_d = pc_q + PcStep;
                        if (cnt_q == 2'd0) begin
                            state_d = StRun;
                            flush_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        pc_out      = pc_q;
        fetch_valid = valid_q;
        if_id_flush = flush_q;
        lr_we       = lr_we_q;
        lr_data     = lr_data_q;
        taken_count = count_q;
    end

endmodule
